// File: rtl/synth_voice_allocator_if.sv
// Note-event handshake between the keyboard decode path and the voice allocator.
interface synth_voice_allocator_if #(
    parameter int NOTE_W = 5
);
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_release;
    logic [NOTE_W-1:0] ev_note;

    // Event source side
    modport master (
        output ev_valid,
        output ev_release,
        output ev_note,
        input  ev_ready
    );

    // Allocator side
    modport slave (
        input  ev_valid,
        input  ev_release,
        input  ev_note,
        output ev_ready
    );
endinterface

// File: rtl/synth_voice_allocator.sv
// Polyphony controller: assigns note press/release events to oscillator slots,
// scanning one voice per cycle and stealing the least-recently-allocated voice
// when every slot is busy.
module synth_voice_allocator #(
    parameter int VOICES = 4,
    parameter int NOTE_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    synth_voice_allocator_if.slave   ev,
    output logic [VOICES-1:0]        voice_on,
    output logic [VOICES*NOTE_W-1:0] voice_note,
    output logic                     steal,
    output logic [3:0]               active_cnt
);
    localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [NOTE_W-1:0] NO_NOTE = NOTE_W'(31);
    localparam logic [2:0]        AGE_MAX = 3'(VOICES-1);
    localparam logic [IW-1:0]     S_LAST  = IW'(VOICES-1);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t                         state_q;
    logic                           ev_ready_q;
    logic [VOICES-1:0]              on_q, on_d;
    logic [VOICES-1:0][NOTE_W-1:0]  note_q, note_d;
    logic [VOICES-1:0][2:0]         age_q, age_d;
    logic                           steal_q, steal_d;
    logic [3:0]                     cnt_q;
    logic [IW-1:0]                  s_q;
    logic [IW-1:0]                  hit_idx_q, free_idx_q, old_idx_q;
    logic                           hit_v_q, free_v_q, old_v_q;
    logic                           lat_rel_q;
    logic [NOTE_W-1:0]              lat_note_q;

    function automatic logic [3:0] popcnt(input logic [VOICES-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < VOICES; i++) c = c + 4'(v[i]);
        return c;
    endfunction

    // Next voice state for the COMMIT cycle, from the scan results and latched event
    always_comb begin
        logic          touch;
        logic [IW-1:0] k;
        on_d    = on_q;
        note_d  = note_q;
        age_d   = age_q;
        steal_d = 1'b0;
        touch   = 1'b0;
        k       = '0;
        if (lat_note_q != NO_NOTE) begin
            if (lat_rel_q) begin
                if (hit_v_q) on_d[hit_idx_q] = 1'b0;
            end else if (hit_v_q) begin
                touch = 1'b1;
                k     = hit_idx_q;
            end else if (free_v_q) begin
                on_d[free_idx_q]   = 1'b1;
                note_d[free_idx_q] = lat_note_q;
                touch              = 1'b1;
                k                  = free_idx_q;
            end else if (old_v_q) begin
                note_d[old_idx_q] = lat_note_q;
                steal_d           = 1'b1;
                touch             = 1'b1;
                k                 = old_idx_q;
            end
        end
        // LRU touch: everything newer than k ages by one, k becomes newest
        if (touch) begin
            for (int j = 0; j < VOICES; j++)
                if (age_q[j] < age_q[k]) age_d[j] = age_q[j] + 3'd1;
            age_d[k] = 3'd0;
        end
    end

    // Control FSM: accept in IDLE, examine one voice per SCAN cycle, update in COMMIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ev_ready_q <= 1'b1;
            on_q       <= '0;
            note_q     <= '0;
            for (int i = 0; i < VOICES; i++) age_q[i] <= 3'(VOICES-1-i);
            steal_q    <= 1'b0;
            cnt_q      <= 4'd0;
            s_q        <= '0;
            hit_idx_q  <= '0;
            free_idx_q <= '0;
            old_idx_q  <= '0;
            hit_v_q    <= 1'b0;
            free_v_q   <= 1'b0;
            old_v_q    <= 1'b0;
            lat_rel_q  <= 1'b0;
            lat_note_q <= '0;
        end else begin
            steal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ev.ev_valid && ev_ready_q) begin
                        lat_rel_q  <= ev.ev_release;
                        lat_note_q <= ev.ev_note;
                        hit_v_q    <= 1'b0;
                        free_v_q   <= 1'b0;
                        old_v_q    <= 1'b0;
                        hit_idx_q  <= '0;
                        free_idx_q <= '0;
                        old_idx_q  <= '0;
                        s_q        <= '0;
                        ev_ready_q <= 1'b0;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    // First match wins, so ties go to the lowest voice index
                    if (on_q[s_q] && note_q[s_q] == lat_note_q && !hit_v_q) begin
                        hit_v_q   <= 1'b1;
                        hit_idx_q <= s_q;
                    end
                    if (!on_q[s_q] && !free_v_q) begin
                        free_v_q   <= 1'b1;
                        free_idx_q <= s_q;
                    end
                    if (age_q[s_q] == AGE_MAX) begin
                        old_v_q   <= 1'b1;
                        old_idx_q <= s_q;
                    end
                    if (s_q == S_LAST) state_q <= COMMIT;
                    else               s_q     <= s_q + 1'b1;
                end
                COMMIT: begin
                    on_q       <= on_d;
                    note_q     <= note_d;
                    age_q      <= age_d;
                    steal_q    <= steal_d;
                    cnt_q      <= popcnt(on_d);
                    ev_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ev.ev_ready = ev_ready_q;
    assign voice_on    = on_q;
    assign voice_note  = note_q;
    assign steal       = steal_q;
    assign active_cnt  = cnt_q;
endmodule
